// File: rtl/mem_port_unit.sv
// Memory-side stage of the multicycle RV32I core: req/ack port, IR/old-PC/read-data registers, lane steering.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned requests instead of truncating the low address bits.
module mem_port_unit #(
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_write,
  input  logic        mem_write,
  input  logic        adr_src,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  output logic [31:0] instr,
  output logic [31:0] old_pc,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;
  typedef enum logic [1:0] {K_FETCH = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2} kind_t;

  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t             state_r;
  kind_t              kind_r;
  logic [2:0]         funct3_r;
  logic [1:0]         off_r;
  logic [31:0]        pend_pc_r;
  logic [CNT_W-1:0]   wait_cnt_r;

  logic               req_fetch_s, req_store_s, req_load_s, req_any_s;
  logic [31:0]        req_addr_s;
  logic [2:0]         req_f3_s;
  logic               misalign_s;
  logic               timeout_s;

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return {4{wd[7:0]}};
      3'b001:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    logic [15:0] h;
    sh = rd >> {off, 3'b000};
    h  = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h00_0000, sh[7:0]};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0000, h};
      default: return rd;
    endcase
  endfunction

  // Request decode; fetch has priority over the data-side strobes.
  assign req_fetch_s = ir_write;
  assign req_store_s = ~ir_write & mem_write & adr_src;
  assign req_load_s  = ~ir_write & ~mem_write & adr_src;
  assign req_any_s   = req_fetch_s | req_store_s | req_load_s;
  assign req_addr_s  = ir_write ? pc : alu_result;
  assign req_f3_s    = instr[14:12];
  assign timeout_s   = TO_EN && (state_r == ST_ACCESS) && !mem_ack && (wait_cnt_r == TO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  logic half_s;
  assign half_s = req_store_s ? (req_f3_s == 3'b001) : (req_f3_s[1:0] == 2'b01);

  // Alignment check for the request being decoded this cycle.
  always_comb begin
    misalign_s = 1'b0;
    if (req_fetch_s || (req_f3_s == 3'b010)) begin
      misalign_s = (req_addr_s[1:0] != 2'b00);
    end else if (half_s) begin
      misalign_s = req_addr_s[0];
    end else begin
      misalign_s = 1'b0;
    end
  end
`else
  assign misalign_s = 1'b0;
`endif

  // Stall: held through the request cycle and every ACCESS cycle without ack or timeout.
  always_comb begin
    busy = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s && !misalign_s) busy = 1'b1;
        else                          busy = 1'b0;
      end
      ST_ACCESS: begin
        if (mem_ack || timeout_s) busy = 1'b0;
        else                      busy = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Access FSM with registered port outputs and architectural registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      kind_r     <= K_FETCH;
      funct3_r   <= 3'b000;
      off_r      <= 2'b00;
      pend_pc_r  <= 32'h0000_0000;
      wait_cnt_r <= '0;
      instr      <= RESET_INSTR;
      old_pc     <= 32'h0000_0000;
      read_data  <= 32'h0000_0000;
      fault      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            if (misalign_s) begin
              fault <= 1'b1;
            end else begin
              state_r    <= ST_ACCESS;
              kind_r     <= req_fetch_s ? K_FETCH : (req_store_s ? K_STORE : K_LOAD);
              funct3_r   <= req_f3_s;
              off_r      <= req_addr_s[1:0];
              wait_cnt_r <= '0;
              mem_req    <= 1'b1;
              mem_we     <= req_store_s;
              mem_addr   <= {req_addr_s[31:2], 2'b00};
              mem_wstrb  <= req_store_s ? store_strb(req_f3_s, req_addr_s[1:0]) : 4'b0000;
              mem_wdata  <= store_data(req_f3_s, write_data);
              if (req_fetch_s) pend_pc_r <= pc;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state_r   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            case (kind_r)
              K_FETCH: begin
                instr  <= mem_rdata;
                old_pc <= pend_pc_r;
              end
              K_LOAD:  read_data <= load_ext(funct3_r, off_r, mem_rdata);
              default: ;
            endcase
          end else if (timeout_s) begin
            state_r   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            fault     <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_unit.sv
// Directed + randomized bench for mem_port_unit against a transaction-level reference model.
module tb_mem_port_unit;

  localparam int TO = 4;
  localparam logic [31:0] RST_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ir_write = 1'b0, mem_write = 1'b0, adr_src = 1'b0;
  logic [31:0] pc = '0, alu_result = '0, write_data = '0;
  logic [31:0] instr, old_pc, read_data;
  logic        busy, fault, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_instr, m_old_pc, m_read_data;
  logic        m_fault;

  mem_port_unit #(.RESET_INSTR(RST_INSTR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ir_write(ir_write), .mem_write(mem_write), .adr_src(adr_src),
    .pc(pc), .alu_result(alu_result), .write_data(write_data),
    .instr(instr), .old_pc(old_pc), .read_data(read_data), .busy(busy), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes: kind 1 = load, 2 = store.
  function automatic int size_of(input int kind, input logic [2:0] f3);
    if (kind == 1) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int o, input logic [31:0] rd);
    int n, start;
    logic [31:0] v;
    n = size_of(1, f3);
    start = o - (o % n);
    v = rd >> (8 * start);
    if (n < 4) begin
      v = v & ((32'h1 << (8 * n)) - 32'h1);
      if (f3 < 3'd4 && v[8*n-1]) v = v - (32'h1 << (8 * n));
    end
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input int o);
    int n;
    logic [3:0] s;
    n = size_of(2, f3);
    s = 4'b0000;
    for (int i = 0; i < 4; i++) if (i / n == o / n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n;
    logic [31:0] w;
    n = size_of(2, f3);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic bit model_trap(input int kind, input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (kind == 0) return a[1:0] != 2'b00;
    if (f3 == 3'b010) return a[1:0] != 2'b00;
    if (size_of(kind, f3) == 2) return a[0];
    return 1'b0;
`else
    return (kind < 0) && (f3 == 3'b111) && (a == 32'h0);
`endif
  endfunction

  task automatic model_reset();
    m_instr = RST_INSTR; m_old_pc = '0; m_read_data = '0; m_fault = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_instr"}, instr, m_instr);
    chk({tag, "_old_pc"}, old_pc, m_old_pc);
    chk({tag, "_read_data"}, read_data, m_read_data);
    chk({tag, "_fault"}, {31'b0, fault}, {31'b0, m_fault});
  endtask

  // One transaction from the request cycle to the return to IDLE; kind 0 fetch, 1 load, 2 store.
  task automatic run_access(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_dly, input logic [31:0] rdata, output int busy_cnt);
    logic [2:0] f3;
    bit trap;
    f3 = m_instr[14:12];
    trap = model_trap(kind, f3, addr);
    busy_cnt = 0;
    ir_write  = (kind == 0);
    mem_write = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind == 2);
    adr_src   = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    pc         = (kind == 0) ? addr : $urandom;
    alu_result = (kind == 0) ? $urandom : addr;
    write_data = wd;
    #1;
    chk("req_busy", {31'b0, busy}, {31'b0, !trap});
    if (busy) busy_cnt++;
    @(posedge clk); #1;
    ir_write = 1'b0; mem_write = 1'b0; adr_src = 1'b0;
    if (trap) begin
      m_fault = 1'b1;
      chk("trap_req", {31'b0, mem_req}, 32'h0);
    end else begin
      for (int c = 0; c < 64; c++) begin
        chk("acc_req", {31'b0, mem_req}, 32'h1);
        chk("acc_we", {31'b0, mem_we}, {31'b0, kind == 2});
        chk("acc_addr", mem_addr, {addr[31:2], 2'b00});
        chk("acc_strb", {28'b0, mem_wstrb}, {28'b0, (kind == 2) ? model_strb(f3, int'(addr[1:0])) : 4'b0000});
        if (kind == 2) chk("acc_wdata", mem_wdata, model_wdata(f3, wd));
        ir_write = 1'($urandom_range(0, 1));
        adr_src = 1'($urandom_range(0, 1));
        pc = $urandom; alu_result = $urandom; write_data = $urandom;
        if (c == ack_dly) begin
          mem_ack = 1'b1; mem_rdata = rdata;
          #1;
          chk("ack_busy", {31'b0, busy}, 32'h0);
          @(posedge clk); #1;
          mem_ack = 1'b0; mem_rdata = $urandom;
          if (kind == 0) begin m_instr = rdata; m_old_pc = addr; end
          if (kind == 1) m_read_data = model_load(f3, int'(addr[1:0]), rdata);
          break;
        end else if (c == TO - 1) begin
          mem_rdata = $urandom;
          #1;
          chk("to_busy", {31'b0, busy}, 32'h0);
          @(posedge clk); #1;
          m_fault = 1'b1;
          break;
        end else begin
          mem_rdata = $urandom;
          #1;
          chk("wait_busy", {31'b0, busy}, 32'h1);
          busy_cnt++;
          @(posedge clk); #1;
        end
      end
    end
    ir_write = 1'b0; mem_write = 1'b0; adr_src = 1'b0;
    #1;
    chk("done_req", {31'b0, mem_req}, 32'h0);
    chk("done_strb", {28'b0, mem_wstrb}, 32'h0);
    chk("done_busy", {31'b0, busy}, 32'h0);
    check_regs("done");
  endtask

  task automatic fetch_f3(input logic [2:0] f3);
    int bc;
    run_access(0, {$urandom_range(0, 255), 2'b00} << 2, 32'h0, $urandom_range(0, 2),
               ($urandom & 32'hFFFF_8FFF) | ({29'b0, f3} << 12), bc);
  endtask

  initial begin
    int bc;
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1; #1;
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    check_regs("rst");

    run_access(0, 32'h100, 32'h0, 3, 32'h0050_0093, bc);
    chk("fetch_busy_cycles", bc, 32'd4);
    chk("fetch_instr", instr, 32'h0050_0093);
    chk("fetch_old_pc", old_pc, 32'h100);

    fetch_f3(3'b000);
    run_access(1, 32'h203, 32'h0, 0, 32'h80FF_FFFF, bc);
    chk("lb_value", read_data, 32'hFFFF_FF80);
    chk("lb_busy_cycles", bc, 32'd1);
    fetch_f3(3'b100);
    run_access(1, 32'h203, 32'h0, 1, 32'h80FF_FFFF, bc);
    chk("lbu_value", read_data, 32'h0000_0080);

    fetch_f3(3'b001);
    run_access(2, 32'h102, 32'h1234_ABCD, 0, 32'h0, bc);
    chk("sh_strb_model", {28'b0, model_strb(3'b001, 2)}, 32'hC);
    chk("sh_wdata_model", model_wdata(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);

    fetch_f3(3'b010);
    run_access(1, 32'h300, 32'h0, 99, 32'h0, bc);
    chk("to_busy_cycles", bc, 32'd4);
    chk("to_fault", {31'b0, fault}, 32'h1);
    chk("to_read_data", read_data, 32'h0000_0080);

    // Reset abandons an access in flight; a late ack must change nothing.
    ir_write = 1'b1; pc = 32'h400; #1;
    chk("mid_req_busy", {31'b0, busy}, 32'h1);
    @(posedge clk); #1; ir_write = 1'b0;
    chk("mid_req", {31'b0, mem_req}, 32'h1);
    reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    model_reset();
    chk("mid_rst_req", {31'b0, mem_req}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("mid_ack_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1; mem_ack = 1'b0;
    chk("mid_after_req", {31'b0, mem_req}, 32'h0);
    check_regs("mid");

    fetch_f3(3'b010);
    run_access(1, 32'h202, 32'h0, 0, 32'h1122_3344, bc);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_mis_fault", {31'b0, fault}, 32'h1);
    chk("lw_mis_busy_cycles", bc, 32'd0);
`else
    chk("lw_mis_fault", {31'b0, fault}, 32'h0);
    chk("lw_mis_value", read_data, 32'h1122_3344);
`endif

    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind != 0) fetch_f3(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1; mem_rdata = $urandom; #1;
        chk("idle_ack_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1; mem_ack = 1'b0;
        chk("idle_ack_req", {31'b0, mem_req}, 32'h0);
        check_regs("idle_ack");
      end
      run_access(kind, $urandom, $urandom, $urandom_range(0, TO), $urandom, bc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_unit.md
Name: mem_port_unit

Overview:
- Memory-side stage of the multicycle RV32I core. Sits directly downstream of the FSM controller and consumes its `IRWrite`, `MemWrite` and `AdrSrc` strobes.
- Drives a single variable-latency memory port using a req/ack handshake.
- Owns the instruction register (IR), old-PC register and read-data register.
- Performs byte/half/word lane steering and sign/zero extension.
- Stalls the controller through `busy` until the access completes.

Parameters:
- RESET_INSTR, 32'h00000013, IR value after reset (addi x0,x0,0).
- TIMEOUT_CYCLES, 255, maximum cycles waiting for `mem_ack` before aborting. 0 disables the timeout.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous active-low reset
- ir_write  in  1  controller: fetch request
- mem_write  in  1  controller: store enable
- adr_src  in  1  controller: 0 = PC address, 1 = ALU-result address
- pc  in  32  current PC (fetch address)
- alu_result  in  32  registered ALU result (load/store address)
- write_data  in  32  rs2 store data
- instr  out  32  instruction register
- old_pc  out  32  PC of the instruction held in `instr`
- read_data  out  32  extended load data register
- busy  out  1  stall; the controller holds its state while high
- fault  out  1  sticky access fault (timeout or misalign)
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  word-aligned address ([1:0] = 0)
- mem_wstrb  out  4  byte write strobes
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory completion, valid only while `mem_req` = 1

Behaviour:
- Reset (`reset` = 0 at clk edge): state IDLE, `instr` = RESET_INSTR, `old_pc`/`read_data` = 0, `fault` = 0, `mem_req`/`mem_we` = 0, `mem_wstrb` = 0, wait counter = 0. Reset mid-access abandons the access; any later `mem_ack` is ignored.
- Request decode, sampled only in IDLE. Priority order:
  - FETCH = `ir_write`.
  - STORE = `mem_write` & `adr_src`.
  - LOAD = `adr_src` & ~`mem_write`.
  - None of the above: stay IDLE.
- FSM IDLE:
  - `busy` = 1 combinationally when any request is decoded.
  - At the edge, latch kind, full address, funct3 (`instr[14:12]`) and `write_data`. FETCH also latches `pc` into a pending-PC register.
  - Go to ACCESS.
- FSM ACCESS:
  - `mem_req` = 1. `mem_we` = 1 only for STORE. `mem_addr` = {addr[31:2], 2'b00}.
  - `busy` = 1 while `mem_ack` = 0.
  - Cycle with `mem_ack` = 1: `busy` = 0 and go to IDLE at the edge.
  - FETCH completion: `instr` <= `mem_rdata`, `old_pc` <= pending PC.
  - LOAD completion: `read_data` <= extended data.
  - STORE completion: no register update.
- Minimum latency: request cycle + 1 ACCESS cycle, i.e. 2 cycles when ack arrives immediately.
- Requests arriving in ACCESS are ignored. `mem_ack` seen in IDLE is ignored.
- Load extension (byte offset `o` = addr[1:0]):
  - LB/LBU (000/100): byte `mem_rdata[8o+7:8o]`, sign- or zero-extended.
  - LH/LHU (001/101): half selected by addr[1], sign- or zero-extended.
  - LW (010) and other encodings: whole word.
- Store steering:
  - SB: `mem_wstrb` = 4'b0001 << o; byte replicated in all 4 lanes.
  - SH: `mem_wstrb` = addr[1] ? 4'b1100 : 4'b0011; half replicated in both halves.
  - SW and other encodings: `mem_wstrb` = 4'b1111.
  - `mem_wstrb` = 0 when `mem_we` = 0.
- Timeout (TIMEOUT_CYCLES ≠ 0):
  - Counter increments each ACCESS cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop `mem_req`, set `fault` = 1, go to IDLE with `busy` = 0 that cycle.
  - On timeout, `instr` and `read_data` are unchanged.
  - Counter clears on every entry to ACCESS.
- `fault` is sticky until reset.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned requests are detected in IDLE: FETCH/LW/SW with addr[1:0] ≠ 0, or halfword with addr[0] = 1.
  - A misaligned request never enters ACCESS: `fault` <= 1, `busy` = 0 in the request cycle, no memory access, registers unchanged.
- Undefined: low address bits are silently truncated for the aligned port and the access proceeds normally.

Test Plan:
- Reset with `reset` = 0 for 2 cycles, then release -> `instr` = 32'h00000013, `busy` = 0, `mem_req` = 0, `fault` = 0.
- Fetch, pc = 0x100, ack after 3 ACCESS cycles, `mem_rdata` = 0x00500093 -> `busy` high 4 cycles; `instr` = 0x00500093, `old_pc` = 0x100.
- LB from 0x203, `mem_rdata` = 0x80FFFFFF -> `read_data` = 0xFFFFFF80. The same access as LBU -> `read_data` = 0x00000080.
- SH to 0x102, `write_data` = 0x1234ABCD -> `mem_addr` = 0x100, `mem_wstrb` = 4'b1100, `mem_wdata` = 0xABCDABCD, `mem_we` = 1.
- TIMEOUT_CYCLES = 4, load with no ack -> `mem_req` drops after 4 ACCESS cycles, `fault` = 1, `read_data` unchanged.
- Reset asserted during ACCESS, then `mem_ack` pulse after release -> state IDLE, `mem_req` = 0, no register update. With MEM_MISALIGN_TRAP_EN, LW at 0x202 -> no `mem_req`, `fault` = 1.
